dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Responder end of the core's data-memory port. The core drives the address, write enable and write data in the M stage and expects read data back in the same cycle.
- Contains a word-addressed data RAM plus a small MMIO page:
  - a free-running cycle counter;
  - an output byte FIFO drained through a valid/ready stream to a downstream sink (console/UART bridge).
- Sits beside the core at top level and replaces a bare dmem.

Parameters:
DEPTH, 64, number of 32-bit RAM words; RAM occupies byte addresses 0 .. DEPTH*4-1
FIFO_DEPTH, 8, output FIFO entries (power of two, >=2)
MMIO_BASE, 32'hFFFF_0000, byte base of the MMIO page (64 KiB aligned)

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
MemWriteM  input  1  store strobe from core M stage
ALUResultM  input  32  byte address from core
WriteDataM  input  32  store data from core
ReadDataM  output  32  load data to core, combinational from address and current state
out_valid  output  1  FIFO head available
out_data  output  8  FIFO head byte
out_ready  input  1  sink accepts head this cycle

Behaviour:
- Address decode (ALUResultM[1:0] ignored, word granularity only):
  - RAM hit: address < DEPTH*4.
  - MMIO hit: address[31:16] == MMIO_BASE[31:16]; register selected by address[3:2].
  - Anything else: reads return 0, writes are ignored.
- RAM:
  - Read is combinational: ReadDataM = mem[address[log2(DEPTH)+1:2]].
  - Write occurs on the rising edge when MemWriteM=1.
  - Not cleared by reset.
  - A read in the same cycle as a write to the same word returns the old value.
- MMIO offset 0x0, CYCLE (read-only):
  - 32-bit counter; reset value 0; increments every cycle; wraps from FFFF_FFFF to 0.
  - Read returns the pre-edge value. Writes are ignored.
- MMIO offset 0x4, OUT_DATA (write-only):
  - A store pushes WriteDataM[7:0] into the FIFO. Reads return 0.
  - Push when full, with no pop in the same cycle: data is dropped and sticky ovf is set to 1.
  - Push when full with a pop in the same cycle: accepted, count unchanged, no ovf.
- MMIO offset 0x8, STATUS:
  - Read returns {16'b0, count[7:0], 5'b0, ovf, full, empty}. count is zero-extended to 8 bits.
  - A write with WriteDataM[2]=1 clears ovf. Other bits are ignored.
- MMIO offset 0xC: reserved; reads return 0, writes are ignored.
- FIFO:
  - Circular buffer with read/write pointers and a count of width log2(FIFO_DEPTH)+1.
  - out_valid = (count != 0); out_data = head entry, stable while out_valid=1 and out_ready=0.
  - Pop happens on the rising edge when out_valid && out_ready.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle on a non-empty FIFO: count unchanged, both pointers advance.
  - Push into an empty FIFO: out_valid rises the following cycle, so minimum push-to-out_valid latency is 1 cycle.
  - out_ready while empty: no effect.
- Reset: asserting reset_n low at any time, including mid-stream:
  - immediately clears pointers, count, ovf and CYCLE;
  - out_valid=0, out_data=0, ReadDataM reflects reset state.
  - A handshake in progress is abandoned and its byte is lost.
- Priority: only one store per cycle, so there are no push/clear conflicts. A FIFO pop is independent of the core port.

Test Plan:
- Reset, then SW 0xDEADBEEF to 0x10 and LW 0x10 next cycle -> ReadDataM=0xDEADBEEF. LW 0x12 -> same (low bits ignored). LW 0x1000 (out of range) -> 0.
- Release reset, read CYCLE at cycles 0, 5 and 6 after release -> 0, 5, 6. Force counter near FFFF_FFFF -> observe wrap to 0.
- Hold out_ready=0, SW 0x41..0x48 to MMIO_BASE+4 -> STATUS=0x0000_0802 (count 8, full). A 9th SW 0x49 -> STATUS=0x0000_0806, byte 0x49 dropped. SW 0x4 to MMIO_BASE+8 -> ovf=0.
- Then raise out_ready -> out_data sequence 0x41..0x48 on 8 consecutive cycles, then out_valid=0, STATUS=0x0000_0001.
- With FIFO full, same-cycle push of 0x50 and pop -> count stays 8, ovf=0, 0x50 emerges last.
- Toggle out_ready randomly while pushing 0x00..0x1F -> output order preserved across pointer wrap, no loss, no duplication. Assert reset_n low mid-stream -> out_valid=0 immediately and STATUS=0x0000_0001 after release.

Source files
------------

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Responder side of the core's data-memory port. Holds a word-addressed data
// RAM and a small MMIO page containing a free-running cycle counter and an
// output byte FIFO that drains to a downstream sink over valid/ready.
//
// Ports:
//   clk        - clock, all state updates on rising edge
//   reset_n    - asynchronous active-low reset
//   MemWriteM  - store strobe from core M stage
//   ALUResultM - byte address from core (bits [1:0] ignored)
//   WriteDataM - store data from core
//   ReadDataM  - load data, combinational from address and current state
//   out_valid  - FIFO head available
//   out_data   - FIFO head byte (0 while empty)
//   out_ready  - sink accepts the head byte this cycle
//
// MMIO map (relative to MMIO_BASE):
//   0x0 CYCLE    (RO)  free-running 32-bit cycle counter
//   0x4 OUT_DATA (WO)  store pushes WriteDataM[7:0] into the FIFO
//   0x8 STATUS   (RW)  {16'b0, count, 5'b0, ovf, full, empty}; write bit2 clears ovf
//   0xC reserved
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int          DEPTH      = 64,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready
);

    localparam int               AW        = $clog2(DEPTH);
    localparam int               PW        = $clog2(FIFO_DEPTH);
    localparam int               CW        = PW + 1;
    localparam logic [31:0]      RAM_BYTES = 32'(DEPTH * 4);
    localparam logic [CW-1:0]    CNT_FULL  = CW'(FIFO_DEPTH);

    // Storage arrays: intentionally not reset.
    logic [31:0]   mem   [DEPTH];
    logic [7:0]    fifo  [FIFO_DEPTH];

    logic [31:0]   cycle_q, cycle_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic          ram_hit_s;
    logic          mmio_hit_s;
    logic [1:0]    reg_sel_s;
    logic [AW-1:0] ram_idx_s;
    logic          push_s;
    logic          pop_s;
    logic          accept_s;
    logic          clr_ovf_s;
    logic          full_s;
    logic          empty_s;

    assign ram_hit_s  = (ALUResultM < RAM_BYTES);
    assign mmio_hit_s = (ALUResultM[31:16] == MMIO_BASE[31:16]);
    assign reg_sel_s  = ALUResultM[3:2];
    assign ram_idx_s  = ALUResultM[AW+1:2];

    assign full_s     = (count_q == CNT_FULL);
    assign empty_s    = (count_q == {CW{1'b0}});
    assign pop_s      = !empty_s && out_ready;
    assign push_s     = MemWriteM && mmio_hit_s && (reg_sel_s == 2'd1);
    assign clr_ovf_s  = MemWriteM && mmio_hit_s && (reg_sel_s == 2'd2) && WriteDataM[2];
    // A push into a full FIFO still fits when the head leaves in the same cycle.
    assign accept_s   = push_s && (!full_s || pop_s);

    assign out_valid  = !empty_s;
    assign out_data   = empty_s ? 8'h00 : fifo[rptr_q];

    // RAM write port; a same-cycle read sees the old word.
    always_ff @(posedge clk) begin
        if (MemWriteM && ram_hit_s) begin
            mem[ram_idx_s] <= WriteDataM;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            fifo[wptr_q] <= WriteDataM[7:0];
        end
    end

    // Next-state for counter, pointers, occupancy and sticky overflow.
    always_comb begin
        cycle_d = cycle_q + 32'd1;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        if (accept_s) begin
            wptr_d = wptr_q + PW'(1);
        end else begin
            wptr_d = wptr_q;
        end

        if (pop_s) begin
            rptr_d = rptr_q + PW'(1);
        end else begin
            rptr_d = rptr_q;
        end

        case ({accept_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (push_s && full_s && !pop_s) begin
            ovf_d = 1'b1;
        end else if (clr_ovf_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_q <= 32'd0;
            wptr_q  <= {PW{1'b0}};
            rptr_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
            ovf_q   <= 1'b0;
        end else begin
            cycle_q <= cycle_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Load data mux: RAM, MMIO registers, or zero for unmapped addresses.
    always_comb begin
        ReadDataM = 32'h0000_0000;
        if (ram_hit_s) begin
            ReadDataM = mem[ram_idx_s];
        end else if (mmio_hit_s) begin
            case (reg_sel_s)
                2'd0:    ReadDataM = cycle_q;
                2'd2:    ReadDataM = {16'h0000, 8'(count_q), 5'b00000, ovf_q, full_s, empty_s};
                default: ReadDataM = 32'h0000_0000;
            endcase
        end else begin
            ReadDataM = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vectors, hand-computed
// expectations, one task per feature.
module tb_dmem_responder;

    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic        clk;
    logic        reset_n;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;

    int n_cmp;
    int n_err;

    dmem_responder #(.DEPTH(64), .FIFO_DEPTH(8), .MMIO_BASE(BASE)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .MemWriteM  (MemWriteM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; MemWriteM = 1'b0; ALUResultM = 32'h0; WriteDataM = 32'h0; out_ready = 1'b0;
        step(); step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h exp 00", out_data); end
        ALUResultM = BASE + 32'h8; #1;
        n_cmp++; if (ReadDataM !== 32'h0000_0001) begin n_err++; $display("FAIL reset_status: got %h exp 00000001", ReadDataM); end
        ALUResultM = BASE; #1;
        n_cmp++; if (ReadDataM !== 32'h0) begin n_err++; $display("FAIL reset_cycle: got %h exp 0", ReadDataM); end
    endtask

    task automatic test_cycle();
        ALUResultM = BASE;
        reset_n = 1'b1; #1;
        n_cmp++; if (ReadDataM !== 32'd0) begin n_err++; $display("FAIL cycle_at_0: got %0d exp 0", ReadDataM); end
        repeat (5) step();
        n_cmp++; if (ReadDataM !== 32'd5) begin n_err++; $display("FAIL cycle_at_5: got %0d exp 5", ReadDataM); end
        step();
        n_cmp++; if (ReadDataM !== 32'd6) begin n_err++; $display("FAIL cycle_at_6: got %0d exp 6", ReadDataM); end
        MemWriteM = 1'b1; WriteDataM = 32'h1234_5678;
        step();
        MemWriteM = 1'b0; #1;
        n_cmp++; if (ReadDataM !== 32'd7) begin n_err++; $display("FAIL cycle_write_ignored: got %0d exp 7", ReadDataM); end
        force dut.cycle_q = 32'hFFFF_FFFE;
        #1;
        release dut.cycle_q;
        #1;
        n_cmp++; if (ReadDataM !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL cycle_preset: got %h exp fffffffe", ReadDataM); end
        step();
        n_cmp++; if (ReadDataM !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL cycle_max: got %h exp ffffffff", ReadDataM); end
        step();
        n_cmp++; if (ReadDataM !== 32'h0) begin n_err++; $display("FAIL cycle_wrap: got %h exp 0", ReadDataM); end
    endtask

    task automatic test_ram();
        MemWriteM = 1'b1; ALUResultM = 32'h0; WriteDataM = 32'h0A0A_0A0A; step();
        ALUResultM = 32'h10; WriteDataM = 32'hDEAD_BEEF; step();
        MemWriteM = 1'b0; #1;
        n_cmp++; if (ReadDataM !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ram_lw_10: got %h exp deadbeef", ReadDataM); end
        ALUResultM = 32'h12; #1;
        n_cmp++; if (ReadDataM !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ram_lw_12: got %h exp deadbeef", ReadDataM); end
        ALUResultM = 32'h10; MemWriteM = 1'b1; WriteDataM = 32'h1234_5678; #1;
        n_cmp++; if (ReadDataM !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ram_read_old: got %h exp deadbeef", ReadDataM); end
        step();
        MemWriteM = 1'b0; #1;
        n_cmp++; if (ReadDataM !== 32'h1234_5678) begin n_err++; $display("FAIL ram_overwrite: got %h exp 12345678", ReadDataM); end
        MemWriteM = 1'b1; ALUResultM = 32'hFC; WriteDataM = 32'hCAFE_F00D; step();
        MemWriteM = 1'b0; #1;
        n_cmp++; if (ReadDataM !== 32'hCAFE_F00D) begin n_err++; $display("FAIL ram_last_word: got %h exp cafef00d", ReadDataM); end
        MemWriteM = 1'b1; ALUResultM = 32'h100; WriteDataM = 32'h1111_1111; step();
        ALUResultM = 32'h1000; WriteDataM = 32'h2222_2222; step();
        MemWriteM = 1'b0; ALUResultM = 32'h100; #1;
        n_cmp++; if (ReadDataM !== 32'h0) begin n_err++; $display("FAIL ram_past_end: got %h exp 0", ReadDataM); end
        ALUResultM = 32'h1000; #1;
        n_cmp++; if (ReadDataM !== 32'h0) begin n_err++; $display("FAIL unmapped_1000: got %h exp 0", ReadDataM); end
        ALUResultM = 32'h0; #1;
        n_cmp++; if (ReadDataM !== 32'h0A0A_0A0A) begin n_err++; $display("FAIL ram_no_alias: got %h exp 0a0a0a0a", ReadDataM); end
    endtask

    task automatic test_fifo_fill();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            MemWriteM = 1'b1; ALUResultM = BASE + 32'h4; WriteDataM = 32'h41 + 32'(i);
            if (i == 0) begin
                #1;
                n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL push_latency: got %b exp 0", out_valid); end
            end
            step();
            if (i == 0) begin
                n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL push_valid: got %b exp 1", out_valid); end
            end
        end
        MemWriteM = 1'b0; ALUResultM = BASE + 32'h8; #1;
        n_cmp++; if (ReadDataM !== 32'h0000_0802) begin n_err++; $display("FAIL status_full: got %h exp 00000802", ReadDataM); end
        n_cmp++; if (out_data !== 8'h41) begin n_err++; $display("FAIL head_stable: got %h exp 41", out_data); end
        MemWriteM = 1'b1; ALUResultM = BASE + 32'h4; WriteDataM = 32'h49; step();
        MemWriteM = 1'b0; ALUResultM = BASE + 32'h8; #1;
        n_cmp++; if (ReadDataM !== 32'h0000_0806) begin n_err++; $display("FAIL status_ovf: got %h exp 00000806", ReadDataM); end
        ALUResultM = BASE + 32'h4; #1;
        n_cmp++; if (ReadDataM !== 32'h0) begin n_err++; $display("FAIL outdata_read: got %h exp 0", ReadDataM); end
        ALUResultM = BASE + 32'hC; #1;
        n_cmp++; if (ReadDataM !== 32'h0) begin n_err++; $display("FAIL reserved_read: got %h exp 0", ReadDataM); end
        MemWriteM = 1'b1; ALUResultM = BASE + 32'h8; WriteDataM = 32'hFFFF_FFFB; step();
        MemWriteM = 1'b0; #1;
        n_cmp++; if (ReadDataM !== 32'h0000_0806) begin n_err++; $display("FAIL ovf_kept: got %h exp 00000806", ReadDataM); end
        MemWriteM = 1'b1; WriteDataM = 32'h4; step();
        MemWriteM = 1'b0; #1;
        n_cmp++; if (ReadDataM !== 32'h0000_0802) begin n_err++; $display("FAIL ovf_clear: got %h exp 00000802", ReadDataM); end
    endtask

    task automatic test_drain();
        MemWriteM = 1'b0; ALUResultM = BASE + 32'h8; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL drain_valid[%0d]: got %b exp 1", i, out_valid); end
            n_cmp++; if (out_data !== 8'(8'h41 + i)) begin n_err++; $display("FAIL drain_data[%0d]: got %h exp %h", i, out_data, 8'(8'h41 + i)); end
            step();
        end
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %b exp 0", out_valid); end
        n_cmp++; if (ReadDataM !== 32'h0000_0001) begin n_err++; $display("FAIL drain_status: got %h exp 00000001", ReadDataM); end
        step();
        n_cmp++; if (ReadDataM !== 32'h0000_0001) begin n_err++; $display("FAIL ready_when_empty: got %h exp 00000001", ReadDataM); end
        out_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            MemWriteM = 1'b1; ALUResultM = BASE + 32'h4; WriteDataM = 32'h60 + 32'(i); step();
        end
        WriteDataM = 32'h50; out_ready = 1'b1; #1;
        n_cmp++; if (out_data !== 8'h60) begin n_err++; $display("FAIL fpp_head: got %h exp 60", out_data); end
        step();
        MemWriteM = 1'b0; out_ready = 1'b0; ALUResultM = BASE + 32'h8; #1;
        n_cmp++; if (ReadDataM !== 32'h0000_0802) begin n_err++; $display("FAIL fpp_status: got %h exp 00000802", ReadDataM); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] exp_b;
            exp_b = (i < 7) ? 8'(8'h61 + i) : 8'h50;
            #1;
            n_cmp++; if (out_data !== exp_b || out_valid !== 1'b1) begin n_err++; $display("FAIL fpp_drain[%0d]: got %b/%h exp 1/%h", i, out_valid, out_data, exp_b); end
            step();
        end
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fpp_empty: got %b exp 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        int         nxt;
        int         cyc;
        int         popped;
        logic       do_push;
        logic       do_pop;
        nxt = 0; cyc = 0; popped = 0;
        while ((nxt < 32 || q.size() != 0) && cyc < 400) begin
            out_ready  = 1'($urandom_range(1, 0));
            do_push    = (nxt < 32) && (q.size() < 8);
            MemWriteM  = do_push;
            ALUResultM = BASE + 32'h4;
            WriteDataM = 32'(nxt);
            #1;
            n_cmp++; if (out_valid !== (q.size() != 0)) begin n_err++; $display("FAIL b2b_valid@%0d: got %b exp %b", cyc, out_valid, q.size() != 0); end
            if (q.size() != 0) begin
                n_cmp++; if (out_data !== q[0]) begin n_err++; $display("FAIL b2b_data@%0d: got %h exp %h", cyc, out_data, q[0]); end
            end
            do_pop = out_ready && (q.size() != 0);
            if (do_pop) begin
                void'(q.pop_front());
                popped++;
            end
            if (do_push) begin
                q.push_back(8'(nxt));
                nxt++;
            end
            step();
            cyc++;
        end
        MemWriteM = 1'b0; out_ready = 1'b0;
        n_cmp++; if (cyc >= 400) begin n_err++; $display("FAIL b2b_timeout: got %0d cycles exp <400", cyc); end
        n_cmp++; if (popped !== 32) begin n_err++; $display("FAIL b2b_count: got %0d exp 32", popped); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            MemWriteM = 1'b1; ALUResultM = BASE + 32'h4; WriteDataM = 32'h70 + 32'(i); step();
        end
        MemWriteM = 1'b0; out_ready = 1'b1; ALUResultM = BASE + 32'h8;
        #2;
        reset_n = 1'b0; #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b exp 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL midrst_data: got %h exp 00", out_data); end
        step();
        reset_n = 1'b1; out_ready = 1'b0; #1;
        n_cmp++; if (ReadDataM !== 32'h0000_0001) begin n_err++; $display("FAIL midrst_status: got %h exp 00000001", ReadDataM); end
        MemWriteM = 1'b1; ALUResultM = BASE + 32'h4; WriteDataM = 32'h7A; step();
        MemWriteM = 1'b0; #1;
        n_cmp++; if (out_data !== 8'h7A || out_valid !== 1'b1) begin n_err++; $display("FAIL postrst_push: got %b/%h exp 1/7a", out_valid, out_data); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_cycle();
        test_ram();
        test_fifo_fill();
        test_drain();
        test_full_push_pop();
        test_back_to_back();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
